// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_pkg
//  Brief    : Shared types and helpers for the async FIFO write/read domains.
//  Revision : 1.0  initial release
// ============================================================================
package fifo_pkg;

   // Write-side controller phases: INIT waits out the synchronizer flush.
   typedef enum logic [0:0] {
      INIT = 1'b0,
      RUN  = 1'b1
   } wr_state_e;

   // SOFT_RESET values that enable the synchronous soft reset input.
   localparam int SOFT_RESET_SYNC_A = 2;
   localparam int SOFT_RESET_SYNC_B = 3;

   // Gray helpers operate on a wide container. Callers zero-extend their
   // operand and truncate the result; leading zeros do not disturb either
   // conversion, so one function serves every pointer width up to 32.
   localparam int GRAY_FN_W = 32;

   function automatic logic [GRAY_FN_W-1:0] bin2gray(input logic [GRAY_FN_W-1:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [GRAY_FN_W-1:0] gray2bin(input logic [GRAY_FN_W-1:0] g);
      logic [GRAY_FN_W-1:0] b;
      b[GRAY_FN_W-1] = g[GRAY_FN_W-1];
      for (int i = GRAY_FN_W-2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage
`default_nettype wire

// File: rtl/wr_ptr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : wr_ptr_ctrl
//  Brief    : Async FIFO write-domain controller. Owns the binary/gray write
//             pointer, the memory write strobe/address, and full, almost-full
//             and level flags computed against the synchronized read pointer.
//  Revision : 1.0  initial release
// ============================================================================
module wr_ptr_ctrl
   import fifo_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 4,
   parameter int SYNC_STAGE    = 2,
   parameter int SOFT_RESET    = 3
)(
   input  logic                     clk_i,
   input  logic                     hw_rst_ni,
   input  logic                     sw_rst_i,
   input  logic                     wr_en_i,
   input  logic [ADDRESS_WIDTH:0]   rd_ptr_sync_i,
   input  logic [ADDRESS_WIDTH:0]   afull_value_i,
   output logic [ADDRESS_WIDTH:0]   wr_ptr_gray_o,
   output logic [ADDRESS_WIDTH-1:0] wr_addr_o,
   output logic                     mem_wr_en_o,
   output logic                     wr_full_o,
   output logic                     wr_almost_full_o,
   output logic [ADDRESS_WIDTH:0]   wr_level_o,
   output logic                     wr_ack_o,
   output logic                     overflow_o
);

   localparam int   PTR_W     = ADDRESS_WIDTH + 1;
   localparam int   CNT_W     = $clog2(SYNC_STAGE + 1);
   localparam logic SW_RST_EN = (SOFT_RESET == SOFT_RESET_SYNC_A) ||
                                (SOFT_RESET == SOFT_RESET_SYNC_B);

   wr_state_e          state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [PTR_W-1:0]   bin_q, bin_d;
   logic [PTR_W-1:0]   gray_q, gray_d;
   logic               full_q, full_d;
   logic               afull_q, afull_d;
   logic [PTR_W-1:0]   level_q, level_d;
   logic               ack_q, ack_d;
   logic               ovf_q, ovf_d;

   logic               sw_rst_hit;
   logic               accept;
   logic [PTR_W-1:0]   bin_nxt;
   logic [PTR_W-1:0]   gray_nxt;
   logic [PTR_W-1:0]   rd_bin;
   logic [PTR_W-1:0]   rd_gray_full;
   logic [PTR_W-1:0]   level_nxt;
   logic               full_nxt;
   logic               afull_nxt;

   // Soft reset is tied off at elaboration unless the mode enables it; it
   // also suppresses the write strobe so a resetting cycle never touches memory.
   assign sw_rst_hit = SW_RST_EN & sw_rst_i;
   assign accept     = wr_en_i & ~full_q & (state_q == RUN) & ~sw_rst_hit;

   // Pointer arithmetic and flag look-ahead against the synchronized read pointer.
   always_comb begin
      bin_nxt      = accept ? (bin_q + PTR_W'(1)) : bin_q;
      gray_nxt     = PTR_W'(bin2gray(GRAY_FN_W'(bin_nxt)));
      rd_bin       = PTR_W'(gray2bin(GRAY_FN_W'(rd_ptr_sync_i)));
      // Full in gray space: the write pointer has lapped the read pointer once,
      // which flips the two top gray bits and leaves the rest equal.
      rd_gray_full = {~rd_ptr_sync_i[PTR_W-1:PTR_W-2], rd_ptr_sync_i[PTR_W-3:0]};
      full_nxt     = (gray_nxt == rd_gray_full);
      level_nxt    = bin_nxt - rd_bin;
      afull_nxt    = (level_nxt >= afull_value_i);
   end

   // Next-state logic: INIT holds full until the synchronizer has flushed.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bin_d   = bin_nxt;
      gray_d  = gray_nxt;
      full_d  = full_q;
      afull_d = afull_nxt;
      level_d = level_nxt;
      ack_d   = accept;
      ovf_d   = ovf_q | (wr_en_i & ~accept);

      case (state_q)
         INIT: begin
            full_d = 1'b1;
            if (cnt_q == CNT_W'(SYNC_STAGE)) begin
               state_d = RUN;
               cnt_d   = '0;
               full_d  = full_nxt;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         RUN: begin
            full_d = full_nxt;
         end
         default: begin
            state_d = INIT;
            full_d  = 1'b1;
         end
      endcase

      if (sw_rst_hit) begin
         state_d = INIT;
         cnt_d   = '0;
         bin_d   = '0;
         gray_d  = '0;
         full_d  = 1'b1;
         afull_d = 1'b0;
         level_d = '0;
         ack_d   = 1'b0;
         ovf_d   = 1'b0;
      end
   end

   // State and flag registers with asynchronous hardware reset.
   always_ff @(posedge clk_i or negedge hw_rst_ni) begin
      if (!hw_rst_ni) begin
         state_q <= INIT;
         cnt_q   <= '0;
         bin_q   <= '0;
         gray_q  <= '0;
         full_q  <= 1'b1;
         afull_q <= 1'b0;
         level_q <= '0;
         ack_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bin_q   <= bin_d;
         gray_q  <= gray_d;
         full_q  <= full_d;
         afull_q <= afull_d;
         level_q <= level_d;
         ack_q   <= ack_d;
         ovf_q   <= ovf_d;
      end
   end

   assign wr_ptr_gray_o    = gray_q;
   assign wr_addr_o        = bin_q[ADDRESS_WIDTH-1:0];
   assign mem_wr_en_o      = accept;
   assign wr_full_o        = full_q;
   assign wr_almost_full_o = afull_q;
   assign wr_level_o       = level_q;
   assign wr_ack_o         = ack_q;
   assign overflow_o       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_wr_ptr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wr_ptr_ctrl
//  Brief    : Directed, table-driven bench for wr_ptr_ctrl (ADDRESS_WIDTH=4,
//             SYNC_STAGE=2), with a second instance whose soft reset is off.
//  Revision : 1.0  initial release
// ============================================================================
module tb_wr_ptr_ctrl;

   logic       clk;
   logic       hw_rst_n;
   logic       sw_rst;
   logic       wr_en;
   logic [4:0] rd_ptr;
   logic [4:0] afull_val;

   logic [4:0] gray, level;
   logic [3:0] addr;
   logic       mem_we, full, afull, ack, ovf;

   logic [4:0] n_gray, n_level;
   logic [3:0] n_addr;
   logic       n_mem_we, n_full, n_afull, n_ack, n_ovf;

   int n_chk  = 0;
   int n_pass = 0;

   wr_ptr_ctrl #(.ADDRESS_WIDTH(4), .SYNC_STAGE(2), .SOFT_RESET(3)) dut (
      .clk_i            (clk),
      .hw_rst_ni        (hw_rst_n),
      .sw_rst_i         (sw_rst),
      .wr_en_i          (wr_en),
      .rd_ptr_sync_i    (rd_ptr),
      .afull_value_i    (afull_val),
      .wr_ptr_gray_o    (gray),
      .wr_addr_o        (addr),
      .mem_wr_en_o      (mem_we),
      .wr_full_o        (full),
      .wr_almost_full_o (afull),
      .wr_level_o       (level),
      .wr_ack_o         (ack),
      .overflow_o       (ovf)
   );

   wr_ptr_ctrl #(.ADDRESS_WIDTH(4), .SYNC_STAGE(2), .SOFT_RESET(1)) dut_nsr (
      .clk_i            (clk),
      .hw_rst_ni        (hw_rst_n),
      .sw_rst_i         (sw_rst),
      .wr_en_i          (wr_en),
      .rd_ptr_sync_i    (rd_ptr),
      .afull_value_i    (afull_val),
      .wr_ptr_gray_o    (n_gray),
      .wr_addr_o        (n_addr),
      .mem_wr_en_o      (n_mem_we),
      .wr_full_o        (n_full),
      .wr_almost_full_o (n_afull),
      .wr_level_o       (n_level),
      .wr_ack_o         (n_ack),
      .overflow_o       (n_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       wr_en;
      logic [4:0] rd;
      logic       e_mem;
      logic [3:0] e_addr;
      logic [4:0] e_gray;
      logic       e_full;
      logic       e_afull;
      logic [4:0] e_level;
      logic       e_ack;
      logic       e_ovf;
   } vec_t;

   vec_t       vt [18];
   logic [4:0] gl [16];

   function automatic logic [4:0] g(input logic [4:0] b);
      return b ^ (b >> 1);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, want %0h", name, act, exp);
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      hw_rst_n  = 1'b0;
      sw_rst    = 1'b0;
      wr_en     = 1'b0;
      rd_ptr    = 5'd0;
      afull_val = 5'd14;

      // Gray codes of 1..16.
      gl = '{5'd1, 5'd3, 5'd2, 5'd6, 5'd7, 5'd5, 5'd4, 5'd12,
             5'd13, 5'd15, 5'd14, 5'd10, 5'd11, 5'd9, 5'd8, 5'd24};
      for (int i = 0; i < 16; i++) begin
         vt[i] = '{1'b1, 5'd0, 1'b1, 4'(i), gl[i], (i == 15), (i >= 13),
                   5'(i + 1), 1'b1, 1'b0};
      end
      // 17th write attempt on a full FIFO is dropped.
      vt[16] = '{1'b1, 5'd0, 1'b0, 4'd0, 5'd24, 1'b1, 1'b1, 5'd16, 1'b0, 1'b1};
      // Reader advanced to binary 4 (gray 00110): full and almost-full release.
      vt[17] = '{1'b0, 5'b00110, 1'b0, 4'd0, 5'd24, 1'b0, 1'b0, 5'd12, 1'b0, 1'b1};

      // ---- reset values
      tick();
      tick();
      chk("rst_full",  full,  1);
      chk("rst_afull", afull, 0);
      chk("rst_level", level, 0);
      chk("rst_gray",  gray,  0);
      chk("rst_ack",   ack,   0);
      chk("rst_ovf",   ovf,   0);
      chk("rst_addr",  addr,  0);

      // ---- INIT: full held for the synchronizer flush
      hw_rst_n = 1'b1;
      tick();
      chk("init1_full", full, 1);
      tick();
      chk("init2_full", full, 1);
      tick();
      chk("run_full",  full,  0);
      chk("run_level", level, 0);
      chk("run_gray",  gray,  0);

      // ---- fill to full, overflow, drain release
      for (int i = 0; i < 18; i++) begin
         wr_en  = vt[i].wr_en;
         rd_ptr = vt[i].rd;
         #1;
         chk($sformatf("v%0d_mem",  i), mem_we, vt[i].e_mem);
         chk($sformatf("v%0d_addr", i), addr,   vt[i].e_addr);
         tick();
         chk($sformatf("v%0d_gray",  i), gray,  vt[i].e_gray);
         chk($sformatf("v%0d_full",  i), full,  vt[i].e_full);
         chk($sformatf("v%0d_afull", i), afull, vt[i].e_afull);
         chk($sformatf("v%0d_level", i), level, vt[i].e_level);
         chk($sformatf("v%0d_ack",   i), ack,   vt[i].e_ack);
         chk($sformatf("v%0d_ovf",   i), ovf,   vt[i].e_ovf);
      end

      // ---- wrap-around: reader tracks the writer so level stays at 1
      for (int k = 0; k < 32; k++) begin
         logic [4:0] b;
         b      = 5'(16 + k);
         wr_en  = 1'b1;
         rd_ptr = g(b);
         #1;
         chk($sformatf("w%0d_mem", k),  mem_we, 1);
         chk($sformatf("w%0d_addr", k), addr,   b[3:0]);
         tick();
         chk($sformatf("w%0d_gray", k),  gray,  g(b + 5'd1));
         chk($sformatf("w%0d_level", k), level, 1);
         chk($sformatf("w%0d_full", k),  full,  0);
         if (k == 14) chk("wrap_gray31", gray, 5'b10000);
         if (k == 15) chk("wrap_gray0",  gray, 5'b00000);
      end

      // ---- soft reset mid-fill (binary 16 -> 19, reader at binary 15)
      rd_ptr = g(5'd15);
      for (int k = 0; k < 3; k++) tick();
      chk("pre_sw_level", level, 4);
      chk("pre_sw_gray",  gray,  g(5'd19));
      sw_rst = 1'b1;
      wr_en  = 1'b1;
      tick();
      chk("sw_gray",   gray,  0);
      chk("sw_level",  level, 0);
      chk("sw_full",   full,  1);
      chk("sw_ovf",    ovf,   0);
      chk("sw_ack",    ack,   0);
      chk("sw_addr",   addr,  0);
      chk("nsr_gray",  n_gray,  g(5'd20));
      chk("nsr_level", n_level, 5);
      chk("nsr_ovf",   n_ovf,   1);
      chk("nsr_full",  n_full,  0);
      chk("nsr_ack",   n_ack,   1);
      sw_rst = 1'b0;
      wr_en  = 1'b0;
      rd_ptr = 5'd0;
      tick();
      chk("swinit1_full", full, 1);
      wr_en = 1'b1;
      #1;
      chk("swinit2_mem", mem_we, 0);
      tick();
      chk("swinit2_full", full, 1);
      chk("swinit2_ovf",  ovf,  1);
      chk("swinit2_ack",  ack,  0);
      chk("swinit2_gray", gray, 0);
      wr_en = 1'b0;
      tick();
      chk("swrun_full", full, 0);
      chk("swrun_ovf",  ovf,  1);
      wr_en = 1'b1;
      tick();
      tick();
      chk("swrun_gray",  gray,  5'd3);
      chk("swrun_level", level, 2);
      chk("swrun_ack",   ack,   1);
      wr_en = 1'b0;

      // ---- asynchronous reset between edges
      #2;
      hw_rst_n = 1'b0;
      #1;
      chk("async_gray",  gray,  0);
      chk("async_level", level, 0);
      chk("async_full",  full,  1);
      chk("async_ovf",   ovf,   0);
      chk("async_ack",   ack,   0);
      chk("async_addr",  addr,  0);

      // ---- afull_value = 0 gives almost-full in RUN
      afull_val = 5'd0;
      hw_rst_n  = 1'b1;
      tick();
      tick();
      tick();
      chk("af0_full",  full,  0);
      chk("af0_afull", afull, 1);
      chk("af0_level", level, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/wr_ptr_ctrl.md
Name: wr_ptr_ctrl

Overview:
Write-domain controller for the async FIFO. It owns the binary/gray write pointer, drives the memory write strobe and address, and computes full, almost-full and fill level against the read pointer. That read pointer arrives gray-coded through wr_cdc_sync, and the controller's gray pointer feeds the read-side synchronizer. An INIT phase holds the FIFO full until the synchronizer pipeline has flushed after any reset.

Parameters:
ADDRESS_WIDTH, 4, memory address width; depth = 2**ADDRESS_WIDTH; legal >= 2
SYNC_STAGE, 2, depth of the read-pointer synchronizer; legal 2 or 3
SOFT_RESET, 3, sw_rst honoured only when value is 2 or 3; otherwise ignored

Ports:
clk  in  1  write-domain clock
hw_rst_n  in  1  asynchronous active-low reset
sw_rst  in  1  synchronous soft reset, gated by SOFT_RESET
wr_en  in  1  write request
rd_ptr_sync  in  ADDRESS_WIDTH+1  gray read pointer, already synchronized
afull_value  in  ADDRESS_WIDTH+1  almost-full threshold (level)
wr_ptr_gray  out  ADDRESS_WIDTH+1  registered gray write pointer to read-side sync
wr_addr  out  ADDRESS_WIDTH  memory write address = binary ptr LSBs
mem_wr_en  out  1  memory write strobe (combinational)
wr_full  out  1  registered full flag
wr_almost_full  out  1  registered, level >= afull_value
wr_level  out  ADDRESS_WIDTH+1  registered fill level
wr_ack  out  1  pulse, one cycle after an accepted write
overflow  out  1  sticky: write attempted while blocked

Behaviour:
- Reset (hw_rst_n=0, asynchronous): state=INIT, init counter=0, binary/gray ptr=0, wr_full=1, wr_almost_full=0, wr_level=0, wr_ack=0, overflow=0.
- Soft reset: sw_rst=1 with SOFT_RESET in {2,3} gives the same values at the next clk edge. It has priority over wr_en. For any other SOFT_RESET value, sw_rst has no effect.
- FSM, INIT: wr_full forced 1; counter increments each cycle. After SYNC_STAGE+1 cycles in INIT, go to RUN; wr_full is then recomputed from the pointers (0 after a clean reset).
- FSM, RUN: normal operation; returns to INIT only on reset or an honoured sw_rst.
- Accept: accept = wr_en & ~wr_full & (state==RUN); mem_wr_en = accept (combinational).
- Pointer update: on accept, bin_next = bin+1 mod 2**(ADDRESS_WIDTH+1) and gray_next = bin_next ^ (bin_next>>1). Both registered.
- wr_addr is driven from the registered binary pointer, so the write uses the pre-increment address.
- Full: wr_full(next) = (gray_next == {~rd_ptr_sync[MSB:MSB-1], rd_ptr_sync[MSB-2:0]}), registered. It asserts in the cycle after the write that fills the FIFO.
- Level: wr_level(next) = bin_next - gray2bin(rd_ptr_sync), modulo 2**(ADDRESS_WIDTH+1).
- Almost-full: wr_almost_full(next) = (level_next >= afull_value). afull_value=0 gives a constant 1 in RUN.
- Flag release: full and almost-full deassert one cycle after rd_ptr_sync advances.
- wr_ack: registered copy of accept.
- overflow: set when wr_en=1 and accept=0, in either INIT or RUN. Cleared only by hw_rst_n or an honoured sw_rst.
- Simultaneous events: wr_en in the same cycle that full clears (registered flag still 1) is dropped and sets overflow.
- Changes of rd_ptr_sync while full are valid; flags follow the new value the next cycle.
- Wrap-around: the binary pointer wraps from 2**(ADDRESS_WIDTH+1)-1 to 0; full/empty remain distinguished by the MSB.

Decomposition:
- Package fifo_pkg holds:
  - the state enum {INIT, RUN};
  - SOFT_RESET encoding constants;
  - functions bin2gray and gray2bin, parameterized by width.
- No sub-module inside this block. wr_cdc_sync instances are placed alongside it in the FIFO top.

Test Plan:
- Reset release, defaults (ADDRESS_WIDTH=4, SYNC_STAGE=2, afull_value=14, rd_ptr_sync=0): wr_full=1 for 3 cycles, then 0; wr_level=0; wr_ptr_gray=0.
- Fill to full: 16 back-to-back writes -> wr_addr 0..15 and wr_ptr_gray 0,1,3,2,6…; wr_almost_full=1 the cycle after the 14th write; wr_full=1 after the 16th (level 16). A 17th wr_en -> mem_wr_en=0, wr_ack=0, overflow=1.
- Drain release: rd_ptr_sync=5'b00110 (bin 4) -> next cycle wr_full=0, wr_level=12, wr_almost_full=0.
- Pointer wrap: drive 32 writes with rd_ptr_sync tracking -> binary 31->0 and gray 5'b10000->5'b00000; no spurious full.
- Soft reset mid-fill: sw_rst with SOFT_RESET=3 -> next edge ptr=0, overflow=0, wr_full=1 for 3 cycles. Repeat with SOFT_RESET=1 -> no change.
- Asynchronous reset: drop hw_rst_n between edges -> outputs take reset values immediately, without a clock edge.
